lsharp_reg_sequencer: RTL and testbench

//  Command-driven register-transfer sequencer; drives the select/write side of the LSharp

---
 rtl/lsharp_reg_sequencer_pkg.sv | 58 +++++
 rtl/lsharp_reg_sequencer_if.sv | 37 +++
 rtl/lsharp_reg_sequencer_onehot8.sv | 15 +
 rtl/lsharp_reg_sequencer.sv | 121 ++++++++++++
 tb/tb_lsharp_reg_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/lsharp_reg_sequencer_pkg.sv
// Shared types for the LSharp register-transfer sequencer: op codes, register codes,
// FSM state encoding, latched command payload and op classification helpers.
package lsharp_reg_pkg;

   localparam int unsigned W8     = 8;
   localparam int unsigned W16    = 16;
   localparam int unsigned CODE_W = 3;
   localparam int unsigned SEL_W  = 8;

   typedef enum logic [2:0] {
      OP_MOV8  = 3'd0,
      OP_MOV16 = 3'd1,
      OP_LDI8  = 3'd2,
      OP_LDI16 = 3'd3,
      OP_INC16 = 3'd4,
      OP_DEC16 = 3'd5,
      OP_ILL6  = 3'd6,
      OP_ILL7  = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      R8_W = 3'd0, R8_Z = 3'd1, R8_B = 3'd2, R8_C = 3'd3,
      R8_D = 3'd4, R8_E = 3'd5, R8_H = 3'd6, R8_L = 3'd7
   } reg8_e;

   // Codes 6/7 on the 16-bit side are legal but map to no register.
   typedef enum logic [2:0] {
      R16_WZ = 3'd0, R16_BC = 3'd1, R16_DE = 3'd2, R16_HL = 3'd3,
      R16_SP = 3'd4, R16_PC = 3'd5, R16_NONE6 = 3'd6, R16_NONE7 = 3'd7
   } reg16_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef struct packed {
      op_e               op;
      logic [CODE_W-1:0] src;
      logic [CODE_W-1:0] dst;
      logic [W16-1:0]    imm;
   } cmd_t;

   function automatic logic op_is_16bit(input op_e op);
      return (op == OP_MOV16) || (op == OP_LDI16) || (op == OP_INC16) || (op == OP_DEC16);
   endfunction

   function automatic logic op_has_read(input op_e op);
      return (op == OP_MOV8) || (op == OP_MOV16) || (op == OP_INC16) || (op == OP_DEC16);
   endfunction

   function automatic logic op_is_legal(input op_e op);
      return (op != OP_ILL6) && (op != OP_ILL7);
   endfunction

endpackage

// File: rtl/lsharp_reg_sequencer_if.sv
// Command handshake plus register-file select/strobe/data buses of the sequencer.
interface lsharp_reg_sequencer_if;

   logic        i_Enable;
   logic        i_Cmd_Valid;
   logic        o_Cmd_Ready;
   logic [2:0]  i_Cmd_Op;
   logic [2:0]  i_Cmd_Src;
   logic [2:0]  i_Cmd_Dst;
   logic [15:0] i_Cmd_Imm;
   logic [7:0]  o_Read8;
   logic [7:0]  o_Write8;
   logic [7:0]  o_Bus8;
   logic [7:0]  i_Bus8;
   logic [7:0]  o_Read16;
   logic [7:0]  o_Write16;
   logic [15:0] o_Bus16;
   logic [15:0] i_Bus16;
   logic        o_Done;
   logic        o_Err;
   logic [15:0] o_Result;

   modport slave (
      input  i_Enable, i_Cmd_Valid, i_Cmd_Op, i_Cmd_Src, i_Cmd_Dst, i_Cmd_Imm,
      input  i_Bus8, i_Bus16,
      output o_Cmd_Ready, o_Read8, o_Write8, o_Bus8, o_Read16, o_Write16, o_Bus16,
      output o_Done, o_Err, o_Result
   );

   modport master (
      output i_Enable, i_Cmd_Valid, i_Cmd_Op, i_Cmd_Src, i_Cmd_Dst, i_Cmd_Imm,
      output i_Bus8, i_Bus16,
      input  o_Cmd_Ready, o_Read8, o_Write8, o_Bus8, o_Read16, o_Write16, o_Bus16,
      input  o_Done, o_Err, o_Result
   );

endinterface

// File: rtl/lsharp_reg_sequencer_onehot8.sv
// 3-bit register code to one-hot select; all zero when not enabled.
module lsharp_onehot8
   import lsharp_reg_pkg::*;
(
   input  logic [CODE_W-1:0] i_code,
   input  logic              i_en,
   output logic [SEL_W-1:0]  o_onehot_c
);

   always_comb begin
      o_onehot_c = '0;
      if (i_en) o_onehot_c[i_code] = 1'b1;
   end

endmodule

// File: rtl/lsharp_reg_sequencer.sv
// Command-driven register-transfer sequencer: read -> optional +/-1 -> write, one command
// per handshake. Strobes are decoded only from registered state and latched fields.
module lsharp_reg_sequencer
   import lsharp_reg_pkg::*;
(
   input logic                    i_Clk,
   input logic                    i_Reset,
   lsharp_reg_sequencer_if.slave  bus
);

   state_e         state_q, state_d;
   cmd_t           cmd_q, cmd_d;
   logic [W16-1:0] temp_q, temp_d;
   logic [W16-1:0] result_q, result_d;

   logic           rd_active_c;
   logic           wr_active_c;
   logic           op16_c;
   logic [W16-1:0] rd16_c;
   op_e            in_op_c;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q  <= ST_IDLE;
         cmd_q    <= '0;
         temp_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         temp_q   <= temp_d;
         result_q <= result_d;
      end
   end

   // 16-bit codes 6/7 have no backing register and read as zero.
   assign rd16_c  = (cmd_q.src >= CODE_W'(6)) ? '0 : bus.i_Bus16;
   assign in_op_c = op_e'(bus.i_Cmd_Op);

   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      temp_d   = temp_q;
      result_d = result_q;
      if (bus.i_Enable) begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.i_Cmd_Valid) begin
                  cmd_d.op  = in_op_c;
                  cmd_d.src = bus.i_Cmd_Src;
                  cmd_d.dst = bus.i_Cmd_Dst;
                  cmd_d.imm = bus.i_Cmd_Imm;
                  if (!op_is_legal(in_op_c)) begin
                     state_d = ST_DONE;
                  end else if (op_has_read(in_op_c)) begin
                     state_d = ST_READ;
                  end else begin
                     state_d = ST_WRITE;
                     temp_d  = (in_op_c == OP_LDI8) ? {8'h00, bus.i_Cmd_Imm[7:0]}
                                                    : bus.i_Cmd_Imm;
                  end
               end
            end
            ST_READ: begin
               state_d = ST_WRITE;
               unique case (cmd_q.op)
                  OP_MOV8:  temp_d = {8'h00, bus.i_Bus8};
                  OP_MOV16: temp_d = rd16_c;
                  OP_INC16: temp_d = rd16_c + W16'(1);
                  OP_DEC16: temp_d = rd16_c - W16'(1);
                  default:  temp_d = temp_q;
               endcase
            end
            ST_WRITE: begin
               state_d  = ST_DONE;
               result_d = temp_q;
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign rd_active_c = (state_q == ST_READ);
   assign wr_active_c = (state_q == ST_WRITE);
   assign op16_c      = op_is_16bit(cmd_q.op);

   lsharp_onehot8 u_read8 (
      .i_code     (cmd_q.src),
      .i_en       (rd_active_c && !op16_c),
      .o_onehot_c (bus.o_Read8)
   );

   lsharp_onehot8 u_read16 (
      .i_code     (cmd_q.src),
      .i_en       (rd_active_c && op16_c),
      .o_onehot_c (bus.o_Read16)
   );

   lsharp_onehot8 u_write8 (
      .i_code     (cmd_q.dst),
      .i_en       (wr_active_c && !op16_c),
      .o_onehot_c (bus.o_Write8)
   );

   lsharp_onehot8 u_write16 (
      .i_code     (cmd_q.dst),
      .i_en       (wr_active_c && op16_c),
      .o_onehot_c (bus.o_Write16)
   );

   // The bus not being written this cycle is held at zero.
   assign bus.o_Bus8      = (wr_active_c && !op16_c) ? temp_q[7:0] : '0;
   assign bus.o_Bus16     = (wr_active_c && op16_c) ? temp_q : '0;
   assign bus.o_Cmd_Ready = (state_q == ST_IDLE);
   assign bus.o_Done      = (state_q == ST_DONE);
   assign bus.o_Err       = (state_q == ST_DONE) && !op_is_legal(cmd_q.op);
   assign bus.o_Result    = result_q;

endmodule

// File: tb/tb_lsharp_reg_sequencer.sv
// Directed plus randomized bench for lsharp_reg_sequencer against a per-command model.
module tb_lsharp_reg_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lsharp_reg_sequencer_if sif ();

   lsharp_reg_sequencer dut (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (sif.slave)
   );

   int          total = 0;
   int          bad   = 0;
   bit          mon_on = 1'b0;
   logic [15:0] exp_result = 16'h0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Exclusivity and idle-quiet rules, every cycle.
   always @(negedge clk) begin
      if (mon_on) begin
         chk("excl_read", 32'($onehot0({sif.o_Read8, sif.o_Read16})), 32'(1));
         chk("excl_write", 32'($onehot0({sif.o_Write8, sif.o_Write16})), 32'(1));
         chk("read_and_write", 32'((|{sif.o_Read8, sif.o_Read16}) && (|{sif.o_Write8, sif.o_Write16})), 32'(0));
         chk("bus8_quiet", 32'((sif.o_Write8 == 8'h00) && (sif.o_Bus8 != 8'h00)), 32'(0));
         chk("bus16_quiet", 32'((sif.o_Write16 == 8'h00) && (sif.o_Bus16 != 16'h0000)), 32'(0));
         if (sif.o_Cmd_Ready)
            chk("idle_strobes", 32'({sif.o_Read8, sif.o_Read16, sif.o_Write8, sif.o_Write16}), 32'(0));
      end
   end

   function automatic logic [15:0] model_val(input logic [2:0] op, input logic [15:0] imm,
                                             input logic [7:0] b8, input logic [15:0] b16);
      case (op)
         3'd0:    return {8'h00, b8};
         3'd1:    return b16;
         3'd2:    return {8'h00, imm[7:0]};
         3'd3:    return imm;
         3'd4:    return 16'((32'(b16) + 1) % 65536);
         3'd5:    return 16'((32'(b16) + 65535) % 65536);
         default: return 16'h0000;
      endcase
   endfunction

   task automatic scramble_cmd();
      sif.i_Cmd_Valid = 1'b0;
      sif.i_Cmd_Op    = 3'($urandom);
      sif.i_Cmd_Src   = 3'($urandom);
      sif.i_Cmd_Dst   = 3'($urandom);
      sif.i_Cmd_Imm   = 16'($urandom);
   endtask

   task automatic scramble_bus();
      sif.i_Bus8  = 8'($urandom);
      sif.i_Bus16 = 16'($urandom);
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [2:0] src, input logic [2:0] dst,
                          input logic [15:0] imm, input logic [7:0] b8, input logic [15:0] b16,
                          input int rstall, input int dstall);
      logic        is16, hasrd, legal;
      logic [7:0]  sel_src, sel_dst;
      logic [15:0] exp;
      is16  = (op == 3'd1) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
      hasrd = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd5);
      legal = (op <= 3'd5);
      if (is16 && hasrd && src >= 3'd6) b16 = 16'h0000;
      exp     = model_val(op, imm, b8, b16);
      sel_src = 8'b1 << src;
      sel_dst = 8'b1 << dst;

      chk("ready_before_accept", 32'(sif.o_Cmd_Ready), 32'(1));
      sif.i_Enable    = 1'b1;
      sif.i_Cmd_Valid = 1'b1;
      sif.i_Cmd_Op    = op;
      sif.i_Cmd_Src   = src;
      sif.i_Cmd_Dst   = dst;
      sif.i_Cmd_Imm   = imm;
      step();
      scramble_cmd();

      if (!legal) begin
         chk("illegal_done", 32'(sif.o_Done), 32'(1));
         chk("illegal_err", 32'(sif.o_Err), 32'(1));
         chk("illegal_ready", 32'(sif.o_Cmd_Ready), 32'(0));
         chk("illegal_result_held", 32'(sif.o_Result), 32'(exp_result));
         step();
         chk("illegal_done_drop", 32'(sif.o_Done), 32'(0));
         chk("illegal_ready_back", 32'(sif.o_Cmd_Ready), 32'(1));
         return;
      end

      if (hasrd) begin
         for (int i = 0; i < rstall; i++) begin
            sif.i_Enable = 1'b0;
            scramble_bus();
            chk("stall_read_sel", 32'(is16 ? sif.o_Read16 : sif.o_Read8), 32'(sel_src));
            chk("stall_no_done", 32'(sif.o_Done), 32'(0));
            step();
         end
         sif.i_Enable = 1'b1;
         sif.i_Bus8   = b8;
         sif.i_Bus16  = b16;
         chk("read_sel", 32'(is16 ? sif.o_Read16 : sif.o_Read8), 32'(sel_src));
         chk("read_other_zero", 32'(is16 ? sif.o_Read8 : sif.o_Read16), 32'(0));
         chk("read_no_done", 32'(sif.o_Done), 32'(0));
         step();
         scramble_bus();
      end

      chk("write_sel", 32'(is16 ? sif.o_Write16 : sif.o_Write8), 32'(sel_dst));
      chk("write_other_zero", 32'(is16 ? sif.o_Write8 : sif.o_Write16), 32'(0));
      chk("write_data", 32'(is16 ? sif.o_Bus16 : {8'h00, sif.o_Bus8}), 32'(is16 ? exp : {8'h00, exp[7:0]}));
      chk("write_result_old", 32'(sif.o_Result), 32'(exp_result));
      chk("write_no_done", 32'(sif.o_Done), 32'(0));
      step();

      exp_result = exp;
      chk("done", 32'(sif.o_Done), 32'(1));
      chk("done_err", 32'(sif.o_Err), 32'(0));
      chk("done_ready", 32'(sif.o_Cmd_Ready), 32'(0));
      chk("result", 32'(sif.o_Result), 32'(exp_result));
      for (int i = 0; i < dstall; i++) begin
         sif.i_Enable = 1'b0;
         step();
         chk("done_stretch", 32'(sif.o_Done), 32'(1));
      end
      sif.i_Enable = 1'b1;
      step();
      chk("done_drop", 32'(sif.o_Done), 32'(0));
      chk("ready_back", 32'(sif.o_Cmd_Ready), 32'(1));
      chk("result_hold", 32'(sif.o_Result), 32'(exp_result));
   endtask

   initial begin
      rst          = 1'b1;
      sif.i_Enable = 1'b0;
      scramble_cmd();
      scramble_bus();
      step();
      step();

      // Reset state, reached with enable low.
      chk("rst_ready", 32'(sif.o_Cmd_Ready), 32'(1));
      chk("rst_strobes", 32'({sif.o_Read8, sif.o_Read16, sif.o_Write8, sif.o_Write16}), 32'(0));
      chk("rst_bus8", 32'(sif.o_Bus8), 32'(0));
      chk("rst_bus16", 32'(sif.o_Bus16), 32'(0));
      chk("rst_done_err", 32'({sif.o_Done, sif.o_Err}), 32'(0));
      chk("rst_result", 32'(sif.o_Result), 32'(0));
      rst          = 1'b0;
      sif.i_Enable = 1'b1;
      mon_on       = 1'b1;
      step();

      run_cmd(3'd3, 3'd0, 3'd1, 16'h1234, 8'h00, 16'h0000, 0, 0);  // LDI16
      run_cmd(3'd0, 3'd3, 3'd6, 16'h0000, 8'h34, 16'h0000, 0, 0);  // MOV8
      run_cmd(3'd4, 3'd5, 3'd5, 16'h0000, 8'h00, 16'hFFFF, 0, 0);  // INC16 wrap
      run_cmd(3'd5, 3'd4, 3'd4, 16'h0000, 8'h00, 16'h0000, 0, 0);  // DEC16 wrap
      run_cmd(3'd1, 3'd2, 3'd3, 16'h0000, 8'h00, 16'hBEEF, 3, 0);  // MOV16 with read stall
      run_cmd(3'd6, 3'd1, 3'd2, 16'h5555, 8'h11, 16'h2222, 0, 0);  // illegal
      run_cmd(3'd2, 3'd0, 3'd7, 16'hAB5A, 8'h00, 16'h0000, 0, 2);  // LDI8, done stretched

      // Reset held two cycles during the WRITE cycle of a MOV16 aborts it.
      sif.i_Cmd_Valid = 1'b1;
      sif.i_Cmd_Op    = 3'd1;
      sif.i_Cmd_Src   = 3'd1;
      sif.i_Cmd_Dst   = 3'd2;
      sif.i_Bus16     = 16'h7777;
      step();
      scramble_cmd();
      step();
      chk("abort_write_seen", 32'(sif.o_Write16), 32'(8'h04));
      rst = 1'b1;
      step();
      chk("abort_strobes_1", 32'({sif.o_Read8, sif.o_Read16, sif.o_Write8, sif.o_Write16}), 32'(0));
      chk("abort_ready_1", 32'(sif.o_Cmd_Ready), 32'(1));
      step();
      rst = 1'b0;
      chk("abort_strobes_2", 32'({sif.o_Read8, sif.o_Read16, sif.o_Write8, sif.o_Write16}), 32'(0));
      step();
      exp_result = 16'h0000;
      chk("abort_ready", 32'(sif.o_Cmd_Ready), 32'(1));
      chk("abort_no_done", 32'(sif.o_Done), 32'(0));
      chk("abort_result", 32'(sif.o_Result), 32'(0));
      chk("abort_no_write", 32'({sif.o_Write8, sif.o_Write16}), 32'(0));

      // Randomized commands.
      for (int n = 0; n < 60; n++) begin
         int rs, ds;
         rs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         ds = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         run_cmd(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 16'($urandom),
                 8'($urandom), 16'($urandom), rs, ds);
      end

      mon_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
